// File: rtl/pause_dim_pkg.sv
// Shared types and width helpers for the pause/dim controller.
// Imported by the top and the pixel-shift sub-module.
package pause_dim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      FADE_OUT,
      DIM,
      FADE_IN
   } state_t;

   function automatic int min1_clog2(input longint n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int atten_w(input int max_atten);
      return min1_clog2(longint'(max_atten) + 1);
   endfunction

endpackage

// File: rtl/pause_dim_ctrl_rgb_shift.sv
// One colour channel, right-shifted by the current attenuation.
// Vacated MSBs are zero-filled, so larger shifts mean a darker picture.
module rgb_shift
   import pause_dim_pkg::*;
#(
   parameter int CW = 4,
   parameter int AW = 2
) (
   input  logic [CW-1:0] px_in,
   input  logic [AW-1:0] shamt,
   output logic [CW-1:0] px_out
);

   assign px_out = px_in >> shamt;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges pause sources with a user pause toggle and fades the picture
// down after a long user pause, then back up on unpause.
module pause_dim_ctrl
   import pause_dim_pkg::*;
#(
   parameter int          SRC_N       = 3,
   parameter int          CH          = 3,
   parameter int          CW          = 4,
   parameter int unsigned DIM_CYCLES  = 32'h17D78400,
   parameter int unsigned STEP_CYCLES = 2_000_000,
   parameter int          MAX_ATTEN   = 2,
   localparam int         AW          = atten_w(MAX_ATTEN)
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             pause_btn,
   input  logic [SRC_N-1:0] pause_src,
   input  logic [SRC_N-1:0] src_mask,
   input  logic             ce_pix,
   input  logic [CH*CW-1:0] rgb_in,
   output logic [CH*CW-1:0] rgb_out,
   output logic             pause,
   output logic             user_paused,
   output logic [AW-1:0]    atten,
   output logic             dimmed
);

   localparam int TW = min1_clog2(longint'(DIM_CYCLES) + 1);
   localparam int SW = min1_clog2(longint'(STEP_CYCLES));

   localparam logic [TW-1:0] TMR_END   = TW'(DIM_CYCLES);
   localparam logic [TW-1:0] TMR_FIRST = (DIM_CYCLES == 0) ? '0 : TW'(1);
   localparam logic [SW-1:0] STEP_END  = SW'(STEP_CYCLES - 1);
   localparam logic [AW-1:0] A_MAX     = AW'(MAX_ATTEN);
   localparam logic [AW-1:0] A_ONE     = AW'(1);

   state_t           r_state;
   logic             r_btn_q;
   logic             r_user_paused;
   logic [TW-1:0]    r_timer;
   logic [SW-1:0]    r_step;
   logic [AW-1:0]    r_atten;
   logic [CH*CW-1:0] r_rgb;

   logic [TW-1:0]    w_tmr_nx;
   logic             w_step_end;
   logic [AW-1:0]    w_a_up;
   logic [AW-1:0]    w_a_dn;
   logic [CH*CW-1:0] w_rgb_sh;

   // Timer saturates at DIM_CYCLES so it can never wrap.
   assign w_tmr_nx   = (r_timer >= TMR_END) ? r_timer : r_timer + 1'b1;
   assign w_step_end = (r_step == STEP_END);
   assign w_a_up     = r_atten + A_ONE;
   assign w_a_dn     = r_atten - A_ONE;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_btn_q       <= 1'b0;
         r_user_paused <= 1'b0;
      end else begin
         r_btn_q       <= pause_btn;
         r_user_paused <= r_user_paused ^ (pause_btn & ~r_btn_q);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_step  <= '0;
         r_atten <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_timer <= '0;
               r_step  <= '0;
               r_atten <= '0;
               if (r_user_paused) begin
                  r_state <= COUNT;
                  r_timer <= TMR_FIRST;
               end
            end
            COUNT: begin
               if (!r_user_paused) begin
                  r_state <= IDLE;
                  r_timer <= '0;
               end else begin
                  r_timer <= w_tmr_nx;
                  if (w_tmr_nx >= TMR_END) begin
                     r_state <= FADE_OUT;
                     r_step  <= '0;
                  end
               end
            end
            FADE_OUT: begin
               if (!r_user_paused) begin
                  r_step <= '0;
                  if (r_atten == '0) begin
                     r_state <= IDLE;
                     r_timer <= '0;
                  end else begin
                     r_state <= FADE_IN;
                  end
               end else if (w_step_end) begin
                  r_step  <= '0;
                  r_atten <= w_a_up;
                  if (w_a_up == A_MAX) r_state <= DIM;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            DIM: begin
               if (!r_user_paused) begin
                  r_state <= FADE_IN;
                  r_step  <= '0;
               end
            end
            FADE_IN: begin
               if (r_user_paused) begin
                  r_step  <= '0;
                  r_state <= (r_atten == A_MAX) ? DIM : FADE_OUT;
               end else if (w_step_end) begin
                  r_step  <= '0;
                  r_atten <= w_a_dn;
                  if (w_a_dn == '0) begin
                     r_state <= IDLE;
                     r_timer <= '0;
                  end
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      rgb_shift #(
         .CW (CW),
         .AW (AW)
      ) u_shift (
         .px_in  (rgb_in[c*CW +: CW]),
         .shamt  (r_atten),
         .px_out (w_rgb_sh[c*CW +: CW])
      );
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)    r_rgb <= '0;
      else if (ce_pix) r_rgb <= w_rgb_sh;
   end

   assign rgb_out     = r_rgb;
   assign pause       = r_user_paused | (|(pause_src & src_mask));
   assign user_paused = r_user_paused;
   assign atten       = r_atten;
   assign dimmed      = (r_atten == A_MAX);

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Scoreboarded bench for pause_dim_ctrl with a short idle time and
// short fade steps so whole fades fit in a few dozen clocks.
module tb_pause_dim_ctrl;

   localparam int D  = 10;
   localparam int S  = 4;
   localparam int MA = 2;

   logic        clk_sys   = 1'b0;
   logic        reset_n   = 1'b1;
   logic        pause_btn = 1'b0;
   logic [2:0]  pause_src = '0;
   logic [2:0]  src_mask  = '0;
   logic        ce_pix    = 1'b1;
   logic [11:0] rgb_in    = '0;
   logic [11:0] rgb_out;
   logic        pause;
   logic        user_paused;
   logic [1:0]  atten;
   logic        dimmed;

   int n_pass  = 0;
   int n_total = 0;

   logic [11:0] exp_q[$];
   logic [11:0] exp_px;

   pause_dim_ctrl #(
      .SRC_N       (3),
      .CH          (3),
      .CW          (4),
      .DIM_CYCLES  (D),
      .STEP_CYCLES (S),
      .MAX_ATTEN   (MA)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .pause_btn   (pause_btn),
      .pause_src   (pause_src),
      .src_mask    (src_mask),
      .ce_pix      (ce_pix),
      .rgb_in      (rgb_in),
      .rgb_out     (rgb_out),
      .pause       (pause),
      .user_paused (user_paused),
      .atten       (atten),
      .dimmed      (dimmed)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [11:0] shr(input logic [11:0] px, input int a);
      logic [11:0] r;
      for (int c = 0; c < 3; c++) r[c*4 +: 4] = px[c*4 +: 4] >> a;
      return r;
   endfunction

   // Expected attenuation after edge k, counted from the edge that
   // raised user_paused, for an uninterrupted fade-out.
   function automatic int fade_a(input int k);
      if (k >= D + 2*S) return 2;
      if (k >= D + S) return 1;
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if (user_paused !== 1'b0)
         $display("FAIL por_user_paused got %b want 0", user_paused);
      else n_pass++;
      n_total++;
      if (atten !== 2'd0) $display("FAIL por_atten got %0d want 0", atten);
      else n_pass++;
      n_total++;
      if (rgb_out !== 12'h000) $display("FAIL por_rgb got %h want 000", rgb_out);
      else n_pass++;
      n_total++;
      if (dimmed !== 1'b0) $display("FAIL por_dimmed got %b want 0", dimmed);
      else n_pass++;
      pause_src = 3'b001;
      src_mask  = 3'b001;
      #1;
      n_total++;
      if (pause !== 1'b1) $display("FAIL por_pause_src got %b want 1", pause);
      else n_pass++;
      pause_src = '0;
      src_mask  = '0;
      tick;
      tick;
      reset_n = 1'b1;
      rgb_in  = 12'hA5C;
      exp_q.push_back(shr(rgb_in, 0));
      tick;
      exp_px = exp_q.pop_front();
      n_total++;
      if (rgb_out !== exp_px)
         $display("FAIL por_first_px got %h want %h", rgb_out, exp_px);
      else n_pass++;
   endtask

   task automatic test_toggle_mask;
      pause_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         n_total++;
         if (user_paused !== 1'b1)
            $display("FAIL hold_toggle clk%0d got %b want 1", i, user_paused);
         else n_pass++;
      end
      pause_btn = 1'b0;
      tick;
      n_total++;
      if (user_paused !== 1'b1)
         $display("FAIL release_keep got %b want 1", user_paused);
      else n_pass++;
      pause_src = 3'b010;
      src_mask  = 3'b000;
      #1;
      n_total++;
      if (pause !== 1'b1) $display("FAIL masked_user got %b want 1", pause);
      else n_pass++;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      n_total++;
      if (pause !== 1'b0) $display("FAIL masked_src got %b want 0", pause);
      else n_pass++;
      src_mask = 3'b010;
      #1;
      n_total++;
      if (pause !== 1'b1) $display("FAIL unmasked_src got %b want 1", pause);
      else n_pass++;
      rgb_in = 12'h9E7;
      for (int i = 0; i < 25; i++) begin
         exp_q.push_back(shr(rgb_in, 0));
         tick;
         exp_px = exp_q.pop_front();
         n_total++;
         if (rgb_out !== exp_px || atten !== 2'd0)
            $display("FAIL src_no_dim clk%0d got %h/%0d want %h/0",
                     i, rgb_out, atten, exp_px);
         else n_pass++;
      end
      pause_src = '0;
      src_mask  = '0;
      #1;
      n_total++;
      if (pause !== 1'b0) $display("FAIL src_drop got %b want 0", pause);
      else n_pass++;
   endtask

   task automatic test_fade_out;
      rgb_in    = 12'hF8C;
      pause_btn = 1'b1;
      exp_q.push_back(shr(rgb_in, 0));
      tick;
      pause_btn = 1'b0;
      exp_px = exp_q.pop_front();
      n_total++;
      if (rgb_out !== exp_px || user_paused !== 1'b1)
         $display("FAIL fo_start got %h/%b want %h/1",
                  rgb_out, user_paused, exp_px);
      else n_pass++;
      for (int k = 1; k <= D + 2*S + 100; k++) begin
         exp_q.push_back(shr(rgb_in, fade_a(k-1)));
         tick;
         exp_px = exp_q.pop_front();
         n_total++;
         if (rgb_out !== exp_px)
            $display("FAIL fo_rgb k%0d got %h want %h", k, rgb_out, exp_px);
         else n_pass++;
         n_total++;
         if (atten !== 2'(fade_a(k)) || dimmed !== (fade_a(k) == MA))
            $display("FAIL fo_atten k%0d got %0d/%b want %0d/%b",
                     k, atten, dimmed, fade_a(k), fade_a(k) == MA);
         else n_pass++;
         if (k == D + S + 1) begin
            n_total++;
            if (rgb_out !== 12'h746)
               $display("FAIL fo_half got %h want 746", rgb_out);
            else n_pass++;
         end
         if (k == D + 2*S + 1) begin
            n_total++;
            if (rgb_out !== 12'h323)
               $display("FAIL fo_quarter got %h want 323", rgb_out);
            else n_pass++;
         end
      end
   endtask

   task automatic test_fade_in_reversal;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      n_total++;
      if (user_paused !== 1'b0 || atten !== 2'd2)
         $display("FAIL fi_unpause got %b/%0d want 0/2", user_paused, atten);
      else n_pass++;
      pause_src = 3'b100;
      src_mask  = 3'b100;
      #1;
      n_total++;
      if (pause !== 1'b1) $display("FAIL fi_src_pause got %b want 1", pause);
      else n_pass++;
      for (int j = 1; j <= 5; j++) begin
         tick;
         n_total++;
         if (atten !== ((j < 5) ? 2'd2 : 2'd1))
            $display("FAIL fi_step j%0d got %0d want %0d",
                     j, atten, (j < 5) ? 2 : 1);
         else n_pass++;
      end
      pause_src = '0;
      src_mask  = '0;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      n_total++;
      if (user_paused !== 1'b1 || atten !== 2'd1)
         $display("FAIL rev_pause got %b/%0d want 1/1", user_paused, atten);
      else n_pass++;
      for (int j = 1; j <= 5; j++) begin
         tick;
         n_total++;
         if (atten !== ((j < 5) ? 2'd1 : 2'd2))
            $display("FAIL rev_step j%0d got %0d want %0d",
                     j, atten, (j < 5) ? 1 : 2);
         else n_pass++;
      end
      n_total++;
      if (dimmed !== 1'b1) $display("FAIL rev_dimmed got %b want 1", dimmed);
      else n_pass++;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         tick;
         n_total++;
         if (atten !== ((j < 5) ? 2'd2 : (j < 9) ? 2'd1 : 2'd0))
            $display("FAIL fi_full j%0d got %0d", j, atten);
         else n_pass++;
      end
      n_total++;
      if (dimmed !== 1'b0 || pause !== 1'b0)
         $display("FAIL fi_end got %b/%b want 0/0", dimmed, pause);
      else n_pass++;
   endtask

   task automatic test_early_unpause;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      repeat (5) tick;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      n_total++;
      if (user_paused !== 1'b0)
         $display("FAIL eu_unpause got %b want 0", user_paused);
      else n_pass++;
      tick;
      tick;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      repeat (D + S - 1) tick;
      n_total++;
      if (atten !== 2'd0)
         $display("FAIL eu_no_early got %0d want 0", atten);
      else n_pass++;
      tick;
      n_total++;
      if (atten !== 2'd1)
         $display("FAIL eu_full_wait got %0d want 1", atten);
      else n_pass++;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      repeat (6) tick;
      n_total++;
      if (atten !== 2'd0 || user_paused !== 1'b0)
         $display("FAIL eu_back got %0d/%b want 0/0", atten, user_paused);
      else n_pass++;
   endtask

   task automatic test_ce_gating;
      logic ce_now;
      ce_pix    = 1'b1;
      rgb_in    = 12'($urandom);
      pause_btn = 1'b1;
      exp_q.push_back(shr(rgb_in, 0));
      tick;
      pause_btn = 1'b0;
      exp_px = exp_q.pop_front();
      n_total++;
      if (rgb_out !== exp_px)
         $display("FAIL ce_start got %h want %h", rgb_out, exp_px);
      else n_pass++;
      for (int k = 1; k <= D + 2*S + 6; k++) begin
         ce_now = ((k - 1) % 8 == 6);
         ce_pix = ce_now;
         rgb_in = 12'($urandom);
         if (ce_now) exp_q.push_back(shr(rgb_in, fade_a(k-1)));
         tick;
         if (ce_now) exp_px = exp_q.pop_front();
         n_total++;
         if (rgb_out !== exp_px)
            $display("FAIL ce_rgb k%0d ce%b got %h want %h",
                     k, ce_now, rgb_out, exp_px);
         else n_pass++;
      end
      ce_pix    = 1'b1;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      repeat (10) tick;
      n_total++;
      if (atten !== 2'd0) $display("FAIL ce_end got %0d want 0", atten);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fade;
      rgb_in    = 12'hFFF;
      pause_btn = 1'b1;
      tick;
      pause_btn = 1'b0;
      repeat (D + S) tick;
      n_total++;
      if (atten !== 2'd1 || rgb_out !== 12'hFFF)
         $display("FAIL mr_pre got %0d/%h want 1/fff", atten, rgb_out);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if (atten !== 2'd0 || rgb_out !== 12'h000)
         $display("FAIL mr_async got %0d/%h want 0/000", atten, rgb_out);
      else n_pass++;
      n_total++;
      if (user_paused !== 1'b0 || dimmed !== 1'b0)
         $display("FAIL mr_flags got %b/%b want 0/0", user_paused, dimmed);
      else n_pass++;
      tick;
      tick;
      reset_n = 1'b1;
      exp_q.push_back(shr(rgb_in, 0));
      tick;
      exp_px = exp_q.pop_front();
      n_total++;
      if (rgb_out !== exp_px || rgb_out !== 12'hFFF)
         $display("FAIL mr_release got %h want fff", rgb_out);
      else n_pass++;
      repeat (D + S + 2) tick;
      n_total++;
      if (atten !== 2'd0) $display("FAIL mr_idle got %0d want 0", atten);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      test_toggle_mask;
      test_fade_out;
      test_fade_in_reversal;
      test_early_unpause;
      test_ce_gating;
      test_reset_mid_fade;
      n_total++;
      if (exp_q.size() != 0)
         $display("FAIL sb_leftover got %0d want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pause_dim_ctrl.md
# pause_dim_ctrl

Parametrised pause and screen-dim controller placed between the core's video output (the HVGEN RGB) and `arcade_video`. It merges N maskable pause-request sources with a user pause toggle into one `pause` level. After a programmable idle time under user pause, it fades the picture down through several attenuation levels. On unpause it fades back up. This generalises the single-step "halve RGB after 10 s" behaviour to configurable channels, depth, timeout and a multi-step fade.

## Interface
Parameters:
- `SRC_N`, 3: number of external pause-request sources (hiscore access, OSD, …).
- `CH`, 3: colour channels in `rgb_in` / `rgb_out`.
- `CW`, 4: bits per channel.
- `DIM_CYCLES`, 32'h17D78400: clocks of continuous user pause before the fade starts (10 s at 40 MHz).
- `STEP_CYCLES`, 2_000_000: clocks per attenuation step, for both fade-out and fade-in.
- `MAX_ATTEN`, 2: final right-shift applied to each channel; legal range 1..CW.

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys`: in, 1, system clock.
- `reset_n`: in, 1, asynchronous active-low reset.
- `pause_btn`: in, 1, user pause button, level; each rising edge toggles user pause.
- `pause_src`: in, SRC_N, pause request levels.
- `src_mask`: in, SRC_N, 1 enables the corresponding `pause_src` bit.
- `ce_pix`: in, 1, pixel clock enable.
- `rgb_in`: in, CH*CW, pixel; channel 0 is in the LSBs.
- `rgb_out`: out, CH*CW, attenuated pixel, registered.
- `pause`: out, 1, combined pause level to the core (drives `PAUSE_N` after inversion).
- `user_paused`: out, 1, current user toggle state.
- `atten`: out, $clog2(MAX_ATTEN+1), current shift amount.
- `dimmed`: out, 1, high when `atten == MAX_ATTEN`.

## Operation
- **Button edge:** `btn_q` registers `pause_btn`. A rising edge (`pause_btn & ~btn_q`) toggles `user_paused`.
- **Pause output:** `pause = user_paused | |(pause_src & src_mask)`. This is combinational from the sources and the register.
- **Sources never start dimming.** Only `user_paused` drives the FSM.
- **FSM states:**
  - IDLE: timer=0, atten=0. Goes to COUNT when `user_paused`.
  - COUNT: timer increments each clock. Goes to FADE_OUT when timer reaches DIM_CYCLES. If `!user_paused`, goes to IDLE and clears the timer.
  - FADE_OUT: the step counter runs. At STEP_CYCLES−1 it wraps to 0 and atten increments. Goes to DIM when atten reaches MAX_ATTEN. If `!user_paused`, goes to FADE_IN and clears the step counter.
  - DIM: holds. Goes to FADE_IN on `!user_paused`.
  - FADE_IN: same stepping as FADE_OUT, but atten decrements. Goes to IDLE when atten reaches 0. If `user_paused` is reasserted, goes to FADE_OUT from the current atten with the step counter cleared; there is no new idle wait.
- **Pixel path:** each channel is `rgb_in[c] >> atten`, zero-filled. It is registered only on `ce_pix`.
- **Widths:**
  - The timer is $clog2(DIM_CYCLES+1) bits and saturates; it never wraps.
  - The step counter is $clog2(STEP_CYCLES) bits, minimum 1.

## Timing
- **Reset values** (immediate, asynchronous): `user_paused`=0, `btn_q`=0, state=IDLE, timer=0, step=0, `atten`=0, `rgb_out`=0, `dimmed`=0. `pause` follows the sources.
- **Toggle latency:** `user_paused` changes 1 clock after the rising edge is sampled. A button held high toggles once only.
- **Fade start:** first atten increment occurs DIM_CYCLES + STEP_CYCLES clocks after `user_paused` rises.
- **`rgb_out` latency:** 1 `ce_pix`-qualified clock. It holds its value while `ce_pix`=0. It uses the `atten` value present in the enable cycle.
- **DIM_CYCLES = 0:** COUNT exits to FADE_OUT on its first clock.
- **Source during FADE_IN:** a source asserting during FADE_IN raises `pause` and leaves the fade unaffected.
- **Button edge on the same clock as a state exit condition:** the FSM uses the registered `user_paused`, so the new value acts on the next clock.
- **Reset mid-fade:** the output returns to full brightness at once.

## Structure
- Shared package `pause_dim_pkg`: state enum (IDLE, COUNT, FADE_OUT, DIM, FADE_IN) and a width helper function for `atten`.
- One sub-module: `rgb_shift`, a per-channel combinational right shift by `atten`, generated CH times.
- Everything else lives in the top of the block.

## Test plan
Bench parameters: CH=3, CW=4, DIM_CYCLES=10, STEP_CYCLES=4, MAX_ATTEN=2, `ce_pix`=1.

1. **Reset:** `reset_n`=0 asserted mid-fade with atten=1 → `atten`=0 and `rgb_out`=0 immediately. After release, `rgb_in`=12'hFFF gives `rgb_out`=12'hFFF one clock later.
2. **Toggle and source masking:** hold `pause_btn` for 5 clocks → `user_paused`=1 exactly once. `pause_src`=3'b010 with `src_mask`=3'b000 → `pause` follows `user_paused` only. With `src_mask`=3'b010 → `pause`=1 and the FSM stays IDLE.
3. **Fade-out:** user pause with `rgb_in`=12'hF8C:
   - atten=1 and `rgb_out`=12'h746 at clock 14;
   - atten=2, `dimmed`=1 and `rgb_out`=12'h323 at clock 18;
   - values stay put for 100 further clocks.
4. **Early unpause:** unpause at clock 6 in COUNT → IDLE with timer=0. Re-pause → fade starts 14 clocks later, not 8.
5. **Fade-in and reversal:** unpause in DIM → atten goes 2→1 after 4 clocks. Re-pause during FADE_IN at atten=1 → atten=2 after 4 more clocks, with no 10-clock wait.
6. **`ce_pix` gating:** `ce_pix` pulses every 8th clock during a fade → `rgb_out` changes only on enabled clocks, and each update reflects the `atten` value of that cycle.
